// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Also provides a no-op LOG macro when the codebase does not supply one.
`ifndef LOG
`define LOG(msg)
`endif

package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam int PC_STEP         = 4;
    localparam int EPOCH_W_DEFAULT = 2;

    typedef logic [EPOCH_W_DEFAULT-1:0] epoch_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/redirect/halt bundle between the PC sequencer (master) and its users (slave).
interface pc_sequencer_if #(
    parameter int XLEN    = 32,
    parameter int EPOCH_W = 2
);
    logic               pc_valid;
    logic               pc_ready;
    logic [XLEN-1:0]    pc_out;
    logic [EPOCH_W-1:0] epoch_out;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_target;
    logic               halt_req;
    logic               resume_req;
    logic               halted;
    logic               trap_valid;

    modport master (
        output pc_valid, pc_out, epoch_out, halted, trap_valid,
        input  pc_ready, redirect_valid, redirect_target, halt_req, resume_req
    );

    modport slave (
        input  pc_valid, pc_out, epoch_out, halted, trap_valid,
        output pc_ready, redirect_valid, redirect_target, halt_req, resume_req
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT control, epoch-tagged redirects.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirects jump to TRAP_VECTOR).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
    parameter int              EPOCH_W      = EPOCH_W_DEFAULT
) (
    input logic            clock,
    input logic            reset,
    pc_sequencer_if.master bus
);

    localparam logic [1:0] S_BOOT = BOOT;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_HALT = HALT;

    if (TRAP_VECTOR[1:0] != 2'b00) begin : g_badTrapVector
        $error("TRAP_VECTOR must be word aligned");
    end

    logic [1:0]         r_state;
    logic [XLEN-1:0]    r_pc;
    logic [EPOCH_W-1:0] r_epoch;
    logic               r_trap;

    logic [1:0]         w_nextState;
    logic [XLEN-1:0]    w_nextPc;
    logic [EPOCH_W-1:0] w_nextEpoch;
    logic               w_nextTrap;
    logic               w_fire;

    assign w_fire = (r_state == S_RUN) && bus.pc_ready;

    always_comb begin
        w_nextState = r_state;
        w_nextPc    = r_pc;
        w_nextEpoch = r_epoch;
        w_nextTrap  = 1'b0;

        case (r_state)
            S_BOOT:  w_nextState = S_RUN;
            S_RUN:   if (bus.halt_req) w_nextState = S_HALT;
            S_HALT:  if (!bus.halt_req && bus.resume_req) w_nextState = S_RUN;
            default: w_nextState = S_BOOT;
        endcase

        // Redirect outranks the increment; a same-cycle handshake keeps the old PC/epoch.
        if (bus.redirect_valid) begin
            w_nextEpoch = r_epoch + EPOCH_W'(1);
`ifdef PC_MISALIGN_TRAP_EN
            if (bus.redirect_target[1:0] != 2'b00) begin
                w_nextPc   = TRAP_VECTOR;
                w_nextTrap = 1'b1;
            end else begin
                w_nextPc = bus.redirect_target;
            end
`else
            w_nextPc = bus.redirect_target & ~XLEN'(3);
`endif
        end else if (w_fire) begin
            w_nextPc = r_pc + XLEN'(PC_STEP);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_VECTOR;
            r_epoch <= '0;
            r_trap  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_pc    <= w_nextPc;
            r_epoch <= w_nextEpoch;
            r_trap  <= w_nextTrap;
            if (bus.redirect_valid) `LOG("redirect");
            if (w_nextTrap) `LOG("trap");
            if (r_state == S_RUN && w_nextState == S_HALT) `LOG("halt");
            if (r_state == S_HALT && w_nextState == S_RUN) `LOG("resume");
        end
    end

    assign bus.pc_valid   = (r_state == S_RUN);
    assign bus.halted     = (r_state == S_HALT);
    assign bus.pc_out     = r_pc;
    assign bus.epoch_out  = r_epoch;
    assign bus.trap_valid = r_trap;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table plus randomized run against a reference model.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit          TRAP_BUILD = 1'b1;
    localparam logic [31:0] MIS_PC     = 32'h100;
`else
    localparam bit          TRAP_BUILD = 1'b0;
    localparam logic [31:0] MIS_PC     = 32'h40;
`endif

    typedef struct {
        logic        redir;
        logic [31:0] target;
        logic        ready;
        logic        halt;
        logic        resume;
        logic [31:0] expPc;
        logic [1:0]  expEpoch;
        logic        expValid;
        logic        expHalted;
        logic        expTrap;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   testsRun = 0;
    int   testsFailed = 0;
    vec_t vecs[$];

    bit      mBoot;
    bit      mHalted;
    bit      mTrap;
    longint  mPc;
    int      mEpoch;

    pc_sequencer_if #(.XLEN(32), .EPOCH_W(2)) bus ();

    pc_sequencer #(
        .XLEN(32),
        .RESET_VECTOR(32'h0),
        .TRAP_VECTOR(32'h100),
        .EPOCH_W(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic redir, input logic [31:0] target,
                                 input logic ready, input logic halt, input logic resume);
        bus.redirect_valid  = redir;
        bus.redirect_target = target;
        bus.pc_ready        = ready;
        bus.halt_req        = halt;
        bus.resume_req      = resume;
    endtask

    task automatic addVec(input logic redir, input logic [31:0] target, input logic ready,
                          input logic halt, input logic resume, input logic [31:0] pc,
                          input logic [1:0] epoch, input logic valid, input logic halted,
                          input logic trap);
        vecs.push_back('{redir, target, ready, halt, resume, pc, epoch, valid, halted, trap});
    endtask

    // Reference model: one step of the sequencer's observable behaviour.
    task automatic modelStep(input bit redir, input longint tgt, input bit ready,
                             input bit halt, input bit resume);
        bit running;
        running = !mBoot && !mHalted;
        mTrap = 1'b0;
        if (redir) begin
            mEpoch = (mEpoch + 1) % 4;
            if (TRAP_BUILD && (tgt % 4) != 0) begin
                mPc   = 'h100;
                mTrap = 1'b1;
            end else begin
                mPc = tgt - (tgt % 4);
            end
        end else if (running && ready) begin
            mPc = (mPc + 4) % 64'h1_0000_0000;
        end
        if (mBoot) mBoot = 1'b0;
        else if (running && halt) mHalted = 1'b1;
        else if (mHalted && resume && !halt) mHalted = 1'b0;
    endtask

    initial begin
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Directed sequence following reset release (BOOT cycle happens during row 0).
        addVec(0, 32'h0,        1, 0, 0, 32'h0,        2'd0, 1, 0, 0);
        addVec(0, 32'h0,        1, 0, 0, 32'h4,        2'd0, 1, 0, 0);
        addVec(0, 32'h0,        1, 0, 0, 32'h8,        2'd0, 1, 0, 0);
        addVec(0, 32'h0,        0, 0, 0, 32'h8,        2'd0, 1, 0, 0);
        addVec(0, 32'h0,        0, 0, 0, 32'h8,        2'd0, 1, 0, 0);
        addVec(0, 32'h0,        0, 0, 0, 32'h8,        2'd0, 1, 0, 0);
        addVec(0, 32'h0,        1, 0, 0, 32'hC,        2'd0, 1, 0, 0);
        addVec(1, 32'h40,       1, 0, 0, 32'h40,       2'd1, 1, 0, 0);
        addVec(1, 32'h10,       0, 0, 0, 32'h10,       2'd2, 1, 0, 0);
        addVec(1, 32'h20,       0, 0, 0, 32'h20,       2'd3, 1, 0, 0);
        addVec(1, 32'h30,       0, 0, 0, 32'h30,       2'd0, 1, 0, 0);
        addVec(1, 32'h40,       0, 0, 0, 32'h40,       2'd1, 1, 0, 0);
        addVec(0, 32'h0,        1, 0, 0, 32'h44,       2'd1, 1, 0, 0);
        addVec(0, 32'h0,        1, 1, 0, 32'h48,       2'd1, 0, 1, 0);
        addVec(1, 32'h80,       1, 0, 0, 32'h80,       2'd2, 0, 1, 0);
        addVec(0, 32'h0,        1, 1, 1, 32'h80,       2'd2, 0, 1, 0);
        addVec(0, 32'h0,        0, 0, 1, 32'h80,       2'd2, 1, 0, 0);
        addVec(1, 32'h42,       0, 0, 0, MIS_PC,       2'd3, 1, 0, TRAP_BUILD);
        addVec(0, 32'h0,        0, 0, 0, MIS_PC,       2'd3, 1, 0, 0);
        addVec(1, 32'hFFFFFFFC, 0, 0, 0, 32'hFFFFFFFC, 2'd0, 1, 0, 0);
        addVec(0, 32'h0,        1, 0, 0, 32'h0,        2'd0, 1, 0, 0);
        addVec(1, 32'h200,      1, 0, 0, 32'h200,      2'd1, 1, 0, 0);

        repeat (2) @(negedge clock);
        checkOutput("reset_pc",     {32'h0, bus.pc_out}, 64'h0);
        checkOutput("reset_epoch",  {62'h0, bus.epoch_out}, 64'h0);
        checkOutput("reset_valid",  {63'h0, bus.pc_valid}, 64'h0);
        checkOutput("reset_halted", {63'h0, bus.halted}, 64'h0);
        checkOutput("reset_trap",   {63'h0, bus.trap_valid}, 64'h0);

        reset = 1'b1;
        #1 checkOutput("boot_valid", {63'h0, bus.pc_valid}, 64'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].redir, vecs[i].target, vecs[i].ready, vecs[i].halt, vecs[i].resume);
            @(posedge clock);
            #1;
            checkOutput($sformatf("vec%0d_pc", i),     {32'h0, bus.pc_out},     {32'h0, vecs[i].expPc});
            checkOutput($sformatf("vec%0d_epoch", i),  {62'h0, bus.epoch_out},  {62'h0, vecs[i].expEpoch});
            checkOutput($sformatf("vec%0d_valid", i),  {63'h0, bus.pc_valid},   {63'h0, vecs[i].expValid});
            checkOutput($sformatf("vec%0d_halted", i), {63'h0, bus.halted},     {63'h0, vecs[i].expHalted});
            checkOutput($sformatf("vec%0d_trap", i),   {63'h0, bus.trap_valid}, {63'h0, vecs[i].expTrap});
            @(negedge clock);
        end

        // Asynchronous reset in the middle of RUN must take effect without a clock edge.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_pc",     {32'h0, bus.pc_out}, 64'h0);
        checkOutput("async_epoch",  {62'h0, bus.epoch_out}, 64'h0);
        checkOutput("async_valid",  {63'h0, bus.pc_valid}, 64'h0);
        checkOutput("async_halted", {63'h0, bus.halted}, 64'h0);

        @(negedge clock);
        reset   = 1'b1;
        mBoot   = 1'b1;
        mHalted = 1'b0;
        mTrap   = 1'b0;
        mPc     = 0;
        mEpoch  = 0;

        for (int i = 0; i < 400; i++) begin
            logic        rRedir;
            logic [31:0] rTarget;
            logic        rReady;
            logic        rHalt;
            logic        rResume;
            rRedir  = ($urandom_range(0, 99) < 20);
            rTarget = $urandom;
            rReady  = ($urandom_range(0, 99) < 60);
            rHalt   = ($urandom_range(0, 99) < 8);
            rResume = ($urandom_range(0, 99) < 25);
            applyStimulus(rRedir, rTarget, rReady, rHalt, rResume);
            modelStep(rRedir, longint'(rTarget), rReady, rHalt, rResume);
            @(posedge clock);
            #1;
            checkOutput($sformatf("rnd%0d_pc", i),     {32'h0, bus.pc_out},     64'(mPc));
            checkOutput($sformatf("rnd%0d_epoch", i),  {62'h0, bus.epoch_out},  64'(mEpoch));
            checkOutput($sformatf("rnd%0d_valid", i),  {63'h0, bus.pc_valid},   {63'h0, !mBoot && !mHalted});
            checkOutput($sformatf("rnd%0d_halted", i), {63'h0, bus.halted},     {63'h0, mHalted});
            checkOutput($sformatf("rnd%0d_trap", i),   {63'h0, bus.trap_valid}, {63'h0, mTrap});
            @(negedge clock);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer that replaces the fixed increment-by-4 PC register in the control unit. It issues fetch addresses through a valid/ready handshake and accepts branch/jump redirects from execute. It tags every issued PC with an epoch so downstream stages can discard wrong-path instructions. It also supports a halt/resume request and a configurable reset vector.

## Interface
Parameters:
- XLEN, 32: address width in bits.
- RESET_VECTOR, 0: PC loaded on reset.
- TRAP_VECTOR, 32'h0000_0100: PC loaded on a misaligned redirect (only with the trap feature).
- EPOCH_W, 2: epoch tag width in bits.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- pc_valid  out  1  pc_out is offered to fetch.
- pc_ready  in  1  fetch accepts pc_out this cycle.
- pc_out  out  XLEN  current fetch address.
- epoch_out  out  EPOCH_W  epoch tag of pc_out.
- redirect_valid  in  1  execute requests a control-flow change.
- redirect_target  in  XLEN  new PC.
- halt_req  in  1  stop issuing after the current handshake.
- resume_req  in  1  leave HALT.
- halted  out  1  state is HALT.
- trap_valid  out  1  one-cycle pulse: misaligned redirect was trapped.

## Operation
- States: BOOT, RUN, HALT.
- BOOT lasts exactly one cycle after reset deassertion with pc_valid=0, then moves to RUN.
- RUN holds pc_valid=1. On pc_valid&&pc_ready, pc_out becomes pc_out+4 next cycle. The add wraps modulo 2^XLEN.
- While pc_valid&&!pc_ready with no redirect, pc_out and epoch_out stay stable.
- Redirect has priority over increment in every state:
  - The next pc_out is redirect_target.
  - The next epoch_out is epoch_out+1, wrapping modulo 2^EPOCH_W.
  - A handshake in the same cycle completes with the old PC and old epoch. Downstream treats that PC as stale by epoch.
  - A redirect while the PC is unaccepted withdraws that PC. This is the only permitted change of an offered PC.
- halt_req in RUN moves to HALT next cycle. If a handshake completes in that cycle, the PC still advances by 4.
- HALT holds pc_valid=0 and halted=1.
  - A redirect in HALT updates pc and epoch but the state stays HALT.
  - resume_req moves to RUN next cycle.
  - When halt_req and resume_req are both asserted, halt wins.
- Reset mid-operation, asynchronous, forces:
  - state BOOT, pc_out=RESET_VECTOR, epoch_out=0.
  - pc_valid=0, halted=0, trap_valid=0.

## Timing
- All outputs are registered. Combinational input-to-output paths are not allowed.
- Reset values:
  - pc_out=RESET_VECTOR, epoch_out=0.
  - pc_valid=0, halted=0, trap_valid=0.
- Latency:
  - Handshake to next PC: 1 cycle.
  - Redirect to target offered: 1 cycle.
  - halt_req to pc_valid low: 1 cycle.
  - resume_req to pc_valid high: 1 cycle.
- First pc_valid=1 appears 2 cycles after reset deassertion (BOOT, then RUN).

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - A redirect_target with bits [1:0]≠0 loads TRAP_VECTOR instead of the target.
  - The epoch still increments.
  - trap_valid pulses for one cycle, coincident with the new PC.
  - The state is unchanged.
- PC_MISALIGN_TRAP_EN undefined:
  - redirect_target[1:0] is forced to 0.
  - trap_valid is tied 0.
  - TRAP_VECTOR is unused.

## Structure
- The shared package holds:
  - pc_state_t enum (BOOT, RUN, HALT).
  - PC_STEP constant (4).
  - the epoch typedef sized by EPOCH_W default.
- Single module with one always_ff for state/pc/epoch and one always_comb for next-state. No sub-module.
- Log messages use the existing LOG macro on redirect, trap, halt and resume.

## Test plan
- Reset, hold pc_ready=1 for 4 cycles -> pc_valid rises in cycle 2; pc_out 0,4,8,12; epoch 0.
- pc_ready=0 for 3 cycles at pc=8 -> pc_out stays 8. Raise ready -> next pc is 12.
- Redirect to 0x40 in the same cycle as a handshake at pc=12 -> 12 accepted with epoch 0; next pc_out=0x40 with epoch 1. Four redirects from epoch 1 wrap to epoch 1 (EPOCH_W=2).
- halt_req at pc=0x44 with ready=1 -> next cycle halted=1, pc_valid=0, pc=0x48. Redirect to 0x80 while halted, then resume -> pc_valid=1 at 0x80.
- With PC_MISALIGN_TRAP_EN, redirect to 0x42 -> pc_out=0x100, trap_valid pulses 1 cycle. Without the macro -> pc_out=0x40, trap_valid=0.
- Start at XLEN=32, pc=0xFFFF_FFFC and accept -> next pc_out=0. Reset asserted mid-RUN -> immediately pc_out=RESET_VECTOR, pc_valid=0.
